// File: rtl/lo_puzzle_pkg.sv
// Shared types and constants for the Lights Out puzzle stage.
package lo_puzzle_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, DONE, LOCK} lo_state_e;

  localparam logic [15:0] LO_DISP_DONE = 16'hCAFE;

  // Switch 0 mask lives in the low byte.
  localparam logic [63:0] LO_MASKS_8X8 = 64'hA4D2_EDB5_5AAD_164B;

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/lo_toggle_apply.sv
// Combinational toggle stage: XORs the mask of every switch that flipped into the LED pattern.
module lo_toggle_apply
  import lo_puzzle_pkg::*;
#(
  parameter int               N     = 8,
  parameter logic [N*N-1:0]   MASKS = '0
) (
  input  logic [N-1:0] dip_sw,
  input  logic [N-1:0] dip_prev,
  input  logic [N-1:0] led_in,
  output logic [N-1:0] led_next,
  output logic [4:0]   toggle_cnt
);

  logic [N-1:0]          diff;
  logic [N-1:0][N-1:0]   term;
  logic [15:0]           diff16;

  assign diff = dip_sw ^ dip_prev;

  for (genvar i = 0; i < N; i++) begin : g_sw
    assign term[i] = diff[i] ? MASKS[i*N +: N] : '0;
  end

  always_comb begin
    led_next = led_in;
    for (int i = 0; i < N; i++) led_next = led_next ^ term[i];
  end

  always_comb begin
    diff16 = '0;
    diff16[N-1:0] = diff;
  end

  assign toggle_cnt = popcount(diff16);

endmodule

// File: rtl/lights_out_puzzle_n.sv
// N-switch Lights Out stage: toggles, edge-qualified submit, bounded retries, move counter.
// Optional move budget enabled by `define LO_MOVE_LIMIT_EN.
module lights_out_puzzle_n
  import lo_puzzle_pkg::*;
#(
  parameter int             N         = 8,
  parameter logic [N-1:0]   INIT_PAT  = N'(8'h2B),
  parameter logic [N-1:0]   TARGET    = '0,
  parameter logic [N*N-1:0] MASKS     = (N*N)'(LO_MASKS_8X8),
  parameter int             MAX_TRIES = 3,
  parameter int             MAX_MOVES = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [N-1:0]  dip_sw,
  input  logic          btn_submit,
  input  logic [15:0]   timer_data,
  output logic [31:0]   seg_data,
  output logic [N-1:0]  led_out,
  output logic [15:0]   move_cnt,
  output logic [3:0]    tries_left,
  output logic          wrong,
  output logic          clear,
  output logic          fail
);

  if (N < 2 || N > 16 || MAX_TRIES < 1 || MAX_TRIES > 15 ||
      MAX_MOVES < 1 || MAX_MOVES > 65535) begin : g_bad_param
    $error("lights_out_puzzle_n: parameter out of range");
  end

  lo_state_e     state;
  logic [N-1:0]  dip_prev;
  logic          sub_prev;
  logic [N-1:0]  led_next;
  logic [4:0]    toggle_cnt;
  logic [16:0]   mc_sum;
  logic [15:0]   mc_next;
  logic [15:0]   disp_moves;
  logic          submit;
  logic          limit_hit;

  lo_toggle_apply #(.N(N), .MASKS(MASKS)) u_toggle (
    .dip_sw     (dip_sw),
    .dip_prev   (dip_prev),
    .led_in     (led_out),
    .led_next   (led_next),
    .toggle_cnt (toggle_cnt)
  );

  assign mc_sum  = {1'b0, move_cnt} + 17'(toggle_cnt);
  assign mc_next = mc_sum[16] ? 16'hFFFF : mc_sum[15:0];
  assign submit  = btn_submit & ~sub_prev;

`ifdef LO_MOVE_LIMIT_EN
  // Only an actual move can exhaust the budget; the judged pattern is the post-move one.
  assign limit_hit  = (toggle_cnt != 5'd0) && (32'(mc_next) >= MAX_MOVES) && (led_next != TARGET);
  assign disp_moves = (32'(move_cnt) >= MAX_MOVES) ? 16'd0 : 16'(MAX_MOVES) - move_cnt;
`else
  assign limit_hit  = 1'b0;
  assign disp_moves = move_cnt;
`endif

  always_comb begin
    seg_data = '0;
    if (state == PLAY)      seg_data = {timer_data, disp_moves};
    else if (state == DONE) seg_data = {timer_data, LO_DISP_DONE};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      led_out    <= INIT_PAT;
      move_cnt   <= '0;
      tries_left <= 4'(MAX_TRIES);
      wrong      <= 1'b0;
      clear      <= 1'b0;
      fail       <= 1'b0;
      dip_prev   <= '0;
      sub_prev   <= 1'b0;
    end else begin
      wrong <= 1'b0;
      clear <= 1'b0;
      fail  <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= LOAD;
          LOAD: begin
            led_out    <= INIT_PAT;
            dip_prev   <= dip_sw;
            move_cnt   <= '0;
            tries_left <= 4'(MAX_TRIES);
            sub_prev   <= btn_submit;
            state      <= PLAY;
          end
          PLAY: begin
            led_out  <= led_next;
            move_cnt <= mc_next;
            dip_prev <= dip_sw;
            sub_prev <= btn_submit;
            // Judge the pattern as it stood before this cycle's toggles.
            if (submit && led_out == TARGET) begin
              clear <= 1'b1;
              state <= DONE;
            end else if (submit && tries_left > 4'd1 && !limit_hit) begin
              tries_left <= tries_left - 4'd1;
              wrong      <= 1'b1;
            end else if (submit || limit_hit) begin
              fail  <= 1'b1;
              state <= LOCK;
              if (submit) tries_left <= (tries_left > 4'd1) ? tries_left - 4'd1 : 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lights_out_puzzle_n.sv
// Bench for lights_out_puzzle_n: directed vectors, a per-cycle behavioural model, literal pins.
module tb_lights_out_puzzle_n;

`ifdef LO_MOVE_LIMIT_EN
  localparam int MM = 3;
`else
  localparam int MM = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  dip_sw = '0;
  logic        btn_submit = 1'b0;
  logic [15:0] timer_data = 16'h1234;
  logic [31:0] seg_data;
  logic [7:0]  led_out;
  logic [15:0] move_cnt;
  logic [3:0]  tries_left;
  logic        wrong, clear, fail;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  lights_out_puzzle_n #(.MAX_MOVES(MM)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dip_sw(dip_sw),
    .btn_submit(btn_submit), .timer_data(timer_data), .seg_data(seg_data),
    .led_out(led_out), .move_cnt(move_cnt), .tries_left(tries_left),
    .wrong(wrong), .clear(clear), .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned mtab[8] = '{8'h4B, 8'h16, 8'hAD, 8'h5A, 8'hB5, 8'hED, 8'hD2, 8'hA4};
  string     m_mode;
  logic [7:0] m_led, m_dprev;
  int         m_moves, m_tries;
  bit         m_w, m_c, m_f, m_sprev;

  function automatic logic [7:0] press(input logic [7:0] led, input logic [7:0] flipped);
    logic [7:0] r = led;
    for (int i = 0; i < 8; i++) if (flipped[i]) r = r ^ mtab[i];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = "idle"; m_led = 8'h2B; m_moves = 0; m_tries = 3;
      m_w = 0; m_c = 0; m_f = 0; m_dprev = '0; m_sprev = 0;
    end else begin
      m_w = 0; m_c = 0; m_f = 0;
      if (!enable) m_mode = "idle";
      else if (m_mode == "idle") m_mode = "load";
      else if (m_mode == "load") begin
        m_led = 8'h2B; m_dprev = dip_sw; m_moves = 0; m_tries = 3;
        m_sprev = btn_submit; m_mode = "play";
      end else if (m_mode == "play") begin
        logic [7:0] flipped, after;
        int n, total;
        bit pressed, over;
        flipped = dip_sw ^ m_dprev;
        after   = press(m_led, flipped);
        n       = $countones(flipped);
        total   = (m_moves + n > 65535) ? 65535 : m_moves + n;
        pressed = btn_submit && !m_sprev;
`ifdef LO_MOVE_LIMIT_EN
        over = (n > 0) && (total >= MM) && (after != 8'h00);
`else
        over = 0;
`endif
        if (pressed && m_led == 8'h00) begin m_c = 1; m_mode = "done"; end
        else if (pressed && m_tries > 1 && !over) begin m_tries--; m_w = 1; end
        else if (pressed || over) begin
          m_f = 1; m_mode = "lock";
          if (pressed) m_tries = (m_tries > 1) ? m_tries - 1 : 0;
        end
        m_led = after; m_moves = total; m_dprev = dip_sw; m_sprev = btn_submit;
      end
    end
  end

  function automatic logic [31:0] m_seg();
    int shown;
`ifdef LO_MOVE_LIMIT_EN
    shown = (m_moves >= MM) ? 0 : MM - m_moves;
`else
    shown = m_moves;
`endif
    if (m_mode == "play") return {timer_data, 16'(shown)};
    if (m_mode == "done") return {timer_data, 16'hCAFE};
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("led_out", 32'(led_out), 32'(m_led));
      chk("move_cnt", 32'(move_cnt), 32'(m_moves));
      chk("tries_left", 32'(tries_left), 32'(m_tries));
      chk("wrong", 32'(wrong), 32'(m_w));
      chk("clear", 32'(clear), 32'(m_c));
      chk("fail", 32'(fail), 32'(m_f));
      chk("seg_data", seg_data, m_seg());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter();
    enable = 1'b0; tick();
    enable = 1'b1; tick(2);
  endtask

  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    #1;
    chk("rst led", 32'(led_out), 32'h2B);
    chk("rst moves", 32'(move_cnt), 32'h0);
    chk("rst tries", 32'(tries_left), 32'h3);
    chk("rst pulses", {29'h0, wrong, clear, fail}, 32'h0);
    chk("rst seg", seg_data, 32'h0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int nw;
    tick();
    chk_on = 1'b1;
    chk("reset led", 32'(led_out), 32'h2B);
    chk("reset tries", 32'(tries_left), 32'h3);
    chk("reset seg", seg_data, 32'h0);
    rst_n = 1'b1;
    tick();

`ifdef LO_MOVE_LIMIT_EN
    // Move budget of 3: SW2 toggled three times.
    enter();
    dip_sw ^= 8'h04; tick();
    dip_sw ^= 8'h04; tick();
    chk("budget 2 moves led", 32'(led_out), 32'h2B);
    chk("budget seg remain", 32'(seg_data[15:0]), 32'h1);
    chk("budget no fail yet", 32'(fail), 32'h0);
    dip_sw ^= 8'h04; tick();
    chk("budget fail", 32'(fail), 32'h1);
    chk("budget led", 32'(led_out), 32'h86);
    tick();
    chk("budget fail one cycle", 32'(fail), 32'h0);
    enter();
    dip_sw ^= 8'h01; tick();
    async_reset_check();
    tick(3);
`else
    // 1: solve with SW0, SW1, SW6, SW7.
    enable = 1'b1; tick(2);
    dip_sw ^= 8'h01; tick();
    dip_sw ^= 8'h02; tick();
    dip_sw ^= 8'h40; tick();
    dip_sw ^= 8'h80; tick();
    chk("t1 led", 32'(led_out), 32'h00);
    chk("t1 moves", 32'(move_cnt), 32'h4);
    chk("t1 seg play", seg_data, 32'h1234_0004);
    btn_submit = 1'b1; tick();
    chk("t1 clear", 32'(clear), 32'h1);
    chk("t1 seg done", 32'(seg_data[15:0]), 32'hCAFE);
    btn_submit = 1'b0; tick();
    chk("t1 clear one cycle", 32'(clear), 32'h0);

    // 2: SW2 only, three wrong submits.
    enter();
    chk("t2 entry led", 32'(led_out), 32'h2B);
    dip_sw ^= 8'h04; tick();
    chk("t2 led", 32'(led_out), 32'h86);
    for (int k = 0; k < 3; k++) begin
      btn_submit = 1'b1; tick();
      chk("t2 tries", 32'(tries_left), 32'(2 - k));
      chk("t2 wrong", 32'(wrong), (k < 2) ? 32'h1 : 32'h0);
      chk("t2 fail", 32'(fail), (k == 2) ? 32'h1 : 32'h0);
      btn_submit = 1'b0; tick();
    end
    dip_sw ^= 8'h08; tick();
    chk("t2 lock led", 32'(led_out), 32'h86);

    // 3: submit held 10 cycles.
    enter();
    dip_sw ^= 8'h04; tick();
    btn_submit = 1'b1; nw = 0;
    repeat (10) begin tick(); nw += int'(wrong); end
    chk("t3 wrong pulses", 32'(nw), 32'h1);
    chk("t3 tries", 32'(tries_left), 32'h2);
    btn_submit = 1'b0; tick();

    // 4: SW0 and SW1 together.
    enter();
    dip_sw ^= 8'h03; tick();
    chk("t4 led", 32'(led_out), 32'h76);
    chk("t4 moves", 32'(move_cnt), 32'h2);

    // 5: enable drop mid-play; switches moved while idle are not moves.
    dip_sw ^= 8'h08; tick();
    enable = 1'b0; dip_sw ^= 8'hF0; tick();
    enable = 1'b1; tick(2);
    chk("t5 led", 32'(led_out), 32'h2B);
    chk("t5 moves", 32'(move_cnt), 32'h0);
    chk("t5 tries", 32'(tries_left), 32'h3);
    tick();
    chk("t5 no phantom moves", 32'(move_cnt), 32'h0);

    // Async reset mid-play.
    dip_sw ^= 8'h01; tick();
    async_reset_check();
    tick(3);
`endif
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
